// File: rtl/audio_clip_player.sv
// Clip playback engine: plays a digit clip then a colour clip from a synchronous
// clip ROM into the codec write port, pulsing sampleDone at the end of each clip.
module audio_clip_player #(
    parameter int CLIP_LEN    = 16384,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 24,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redCountAudioRequest,
    input  logic              greenCountAudioRequest,
    input  logic              redAudioRequest,
    input  logic              greenAudioRequest,
    input  logic              sampleDoneAck,
    input  logic [3:0]        redCount,
    input  logic [3:0]        greenCount,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [DATA_W-1:0] romData,
    output logic [DATA_W-1:0] audioOut,
    output logic              audioWrite,
    input  logic              audioReady,
    output logic              sampleDone,
    output logic              busy,
    output logic              ackTimeout
);

    localparam int OFF_W = (CLIP_LEN > 1) ? $clog2(CLIP_LEN) : 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CLIP_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0] IDX_RED   = 4'd10;
    localparam logic [3:0] IDX_GREEN = 4'd11;
    localparam logic PH_COUNT = 1'b0;
    localparam logic PH_COLOR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PUSH, S_DONE, S_WAIT_COLOR
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              phase_q, phase_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] audio_q, audio_d;
    logic              ack_to_q, ack_to_d;

    logic last_sample;
    logic color_accept;

    // Counts above 9 saturate to the "9" clip.
    function automatic logic [3:0] digit_idx(input logic [3:0] c);
        return (c > 4'd9) ? 4'd9 : c;
    endfunction

    assign last_sample  = (offset_q == OFF_LAST);
    assign color_accept = sampleDoneAck && (redAudioRequest || greenAudioRequest);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (redCountAudioRequest || greenCountAudioRequest) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_PUSH;
            S_PUSH: begin
                if (audioReady) begin
                    state_d = last_sample ? S_DONE : S_FETCH;
                end
            end
            S_DONE: state_d = (phase_q == PH_COUNT) ? S_WAIT_COLOR : S_IDLE;
            S_WAIT_COLOR: begin
                if (color_accept) begin
                    state_d = S_FETCH;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        audioWrite = (state_q == S_PUSH);
        sampleDone = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
    end

    always_comb begin
        idx_d    = idx_q;
        phase_d  = phase_q;
        offset_d = offset_q;
        timer_d  = timer_q;
        audio_d  = audio_q;
        ack_to_d = ack_to_q;
        case (state_q)
            S_IDLE: begin
                if (redCountAudioRequest) begin
                    idx_d    = digit_idx(redCount);
                    phase_d  = PH_COUNT;
                    offset_d = '0;
                    ack_to_d = 1'b0;
                end else if (greenCountAudioRequest) begin
                    idx_d    = digit_idx(greenCount);
                    phase_d  = PH_COUNT;
                    offset_d = '0;
                    ack_to_d = 1'b0;
                end
            end
            S_LOAD: audio_d = romData;
            S_PUSH: begin
                if (audioReady && !last_sample) begin
                    offset_d = offset_q + 1'b1;
                end
            end
            S_DONE: timer_d = '0;
            S_WAIT_COLOR: begin
                timer_d = timer_q + 1'b1;
                if (sampleDoneAck && redAudioRequest) begin
                    idx_d    = IDX_RED;
                    phase_d  = PH_COLOR;
                    offset_d = '0;
                end else if (sampleDoneAck && greenAudioRequest) begin
                    idx_d    = IDX_GREEN;
                    phase_d  = PH_COLOR;
                    offset_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    ack_to_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            phase_q  <= PH_COUNT;
            offset_q <= '0;
            timer_q  <= '0;
            audio_q  <= '0;
            ack_to_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            offset_q <= offset_d;
            timer_q  <= timer_d;
            audio_q  <= audio_d;
            ack_to_q <= ack_to_d;
        end
    end

    // Address is held from FETCH so the ROM word lands in LOAD; zero under reset.
    assign romAddr    = ADDR_W'(idx_q) * ADDR_W'(CLIP_LEN) + ADDR_W'(offset_q);
    assign audioOut   = audio_q;
    assign ackTimeout = ack_to_q;

endmodule

// File: doc/audio_clip_player.md
Name: audio_clip_player

Overview:
- Playback engine on the other end of the keyboard controller's audio-request handshake.
- Accepts a count-clip request (digit "0".."9" chosen from the live red/green count), then a colour-clip request ("red"/"green").
- Streams each clip's samples from a synchronous clip ROM into the audio codec's write port.
- Pulses sampleDone once at the end of each clip.

Parameters:
- CLIP_LEN, 16384: samples per clip; all 12 clips are fixed length.
- ADDR_W, 18: ROM address width; must satisfy 12*CLIP_LEN <= 2^ADDR_W.
- DATA_W, 24: audio sample width.
- ACK_TIMEOUT, 1024: cycles to wait in WAIT_COLOR before abandoning the sequence.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- redCountAudioRequest  in  1  one-cycle pulse: play digit clip for redCount.
- greenCountAudioRequest  in  1  one-cycle pulse: play digit clip for greenCount.
- redAudioRequest  in  1  level: play "red" clip.
- greenAudioRequest  in  1  level: play "green" clip.
- sampleDoneAck  in  1  controller acknowledges the count clip completed.
- redCount  in  4  red detections, unsigned.
- greenCount  in  4  green detections, unsigned.
- romAddr  out  ADDR_W  clip ROM address.
- romData  in  DATA_W  ROM data, valid one cycle after romAddr.
- audioOut  out  DATA_W  sample to codec.
- audioWrite  out  1  sample valid.
- audioReady  in  1  codec can accept a sample.
- sampleDone  out  1  one-cycle pulse at end of each clip.
- busy  out  1  high in every state except IDLE.
- ackTimeout  out  1  sticky flag: colour request never arrived.

Behaviour:
- Reset: asynchronous, active-high, to IDLE. All outputs 0: romAddr, audioOut, audioWrite, sampleDone, busy, ackTimeout.
- Clip index mapping:
  - digit d -> index d, where d = min(count, 9) (counts 10..15 play "9").
  - "red" -> index 10; "green" -> index 11.
  - Base address = index*CLIP_LEN.
  - Sample offset counts 0..CLIP_LEN-1; romAddr = base + offset.
- Sample transfer: one sample moves on each cycle where audioWrite && audioReady. audioOut is stable while audioWrite is high.
- FSM states: IDLE, FETCH, LOAD, PUSH, DONE, WAIT_COLOR.
  - IDLE:
    - redCountAudioRequest -> latch index from redCount, phase=COUNT, offset=0, go FETCH.
    - else greenCountAudioRequest -> same, using greenCount.
    - Red wins if both requests are high together.
    - Colour requests are ignored in IDLE.
    - Accepting a count request clears ackTimeout.
  - FETCH: drive romAddr; go LOAD.
  - LOAD: register romData into audioOut; go PUSH.
  - PUSH:
    - audioWrite=1 and held until audioReady.
    - On transfer: if offset==CLIP_LEN-1 go DONE; else offset++ and go FETCH.
  - DONE:
    - sampleDone=1 for exactly this cycle.
    - If phase=COUNT -> WAIT_COLOR with timer=0; if phase=COLOR -> IDLE.
  - WAIT_COLOR:
    - redAudioRequest && sampleDoneAck -> index 10, phase=COLOR, offset=0, go FETCH.
    - else greenAudioRequest && sampleDoneAck -> index 11, same.
    - A colour request without sampleDoneAck is ignored.
    - Timer increments every cycle; at ACK_TIMEOUT-1 with no accepted request -> set ackTimeout, go IDLE.
- Timing with audioReady tied high: 3 cycles per sample. sampleDone asserts 3*CLIP_LEN+1 cycles after the request edge.
- Count requests arriving while busy are dropped, with no queueing.
- The colour request is level and stays high for the whole colour clip. It is only sampled in WAIT_COLOR, so it cannot retrigger.
- sampleDone is never high for two consecutive cycles. The controller advances on level, so this is mandatory.
- Reset mid-clip: immediate abort, outputs 0, no sampleDone.

Test Plan (CLIP_LEN=4, ACK_TIMEOUT=8, ROM word = address):
- Red count path: redCount=3, pulse redCountAudioRequest, audioReady=1.
  - Expect audioOut 12,13,14,15, one transfer every 3 cycles.
  - Expect sampleDone one cycle at request+13.
  - Then assert redAudioRequest and sampleDoneAck together.
  - Expect samples 40..43, a second single sampleDone, then IDLE with busy=0.
- Saturation and priority: greenCount=12, both count pulses in the same cycle with redCount=0.
  - Expect samples 0..3 (red wins).
  - Separate run, green alone: expect samples 36..39.
- Backpressure: audioReady low for 5 cycles during PUSH of sample 2.
  - audioWrite stays high and audioOut stays 2 throughout.
  - No duplicate or dropped samples.
  - sampleDone is delayed by 5 cycles.
- Ack qualification and timeout:
  - After the count clip, greenAudioRequest=1 with sampleDoneAck=0: no playback.
  - After 8 cycles: ackTimeout=1 and state IDLE.
  - Next count request clears ackTimeout.
- Ignored requests: a count pulse during playback, and colour requests while in IDLE.
  - Sample stream unchanged; no extra sampleDone.
- Reset mid-clip: assert reset during PUSH of sample 1.
  - All outputs 0 asynchronously; no sampleDone.
  - A fresh request after release starts at offset 0.
